// File: rtl/uart_cfg_pkg.sv
// Shared types and constants for the UART configuration loader:
// frame parser states, register address map and default frame header.
package uart_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DHI,
    DLO,
    CHK
  } cfg_state_t;

  localparam logic [1:0] ADDR_KP = 2'd0;
  localparam logic [1:0] ADDR_KI = 2'd1;
  localparam logic [1:0] ADDR_KD = 2'd2;
  localparam logic [1:0] ADDR_SP = 2'd3;

  localparam int         NUM_REGS    = 4;
  localparam logic [7:0] HDR_DEFAULT = 8'hA5;

  // Frame checksum: the address byte has its upper six bits forced to zero.
  function automatic logic [7:0] frame_chk(input logic [1:0] addr,
                                           input logic [7:0] d_hi,
                                           input logic [7:0] d_lo);
    return {6'd0, addr} ^ d_hi ^ d_lo;
  endfunction

endpackage

// File: rtl/rdy_edge_sync.sv
// Rising-edge detector for the UART data-ready level. The delay flop resets
// high so a level already present at reset release never counts as a byte.
module rdy_edge_sync (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic rdy,
  output logic byte_stb
);

  logic rdy_d_reg;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rdy_d_reg <= 1'b1;
    end else begin
      rdy_d_reg <= rdy;
    end
  end

  assign byte_stb = rdy & ~rdy_d_reg;

endmodule

// File: rtl/uart_cfg_loader.sv
// Parses HDR/ADDR/D_HI/D_LO/CHK frames from the UART receiver and writes one
// of the four PID configuration registers on a frame with a valid checksum.
module uart_cfg_loader
  import uart_cfg_pkg::*;
#(
  parameter logic [7:0]  HDR            = HDR_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [15:0] KP_RST         = 16'h0000,
  parameter logic [15:0] KI_RST         = 16'h0000,
  parameter logic [15:0] KD_RST         = 16'h0000,
  parameter logic [15:0] SP_RST         = 16'h0000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rx_rdy_in,
  input  logic [7:0]  rx_data_in,
  output logic [15:0] kp_out,
  output logic [15:0] ki_out,
  output logic [15:0] kd_out,
  output logic [15:0] sp_out,
  output logic        cfg_update,
  output logic [1:0]  cfg_addr,
  output logic        frame_err,
  output logic        busy
);

  localparam int            CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  cfg_state_t    state_reg;
  logic [1:0]    addr_reg;
  logic [7:0]    dhi_reg;
  logic [7:0]    dlo_reg;
  logic [CW-1:0] tmo_cnt_reg;
  logic          byte_stb;
  logic          tmo_hit;
  logic          commit_stb;

  function automatic logic [15:0] rst_val(input logic [1:0] idx);
    case (idx)
      ADDR_KP: return KP_RST;
      ADDR_KI: return KI_RST;
      ADDR_KD: return KD_RST;
      default: return SP_RST;
    endcase
  endfunction

  rdy_edge_sync u_rdy_edge (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .rdy      (rx_rdy_in),
    .byte_stb (byte_stb)
  );

  assign tmo_hit    = (tmo_cnt_reg == TMO_LAST);
  assign commit_stb = byte_stb && (state_reg == CHK) &&
                      (rx_data_in == frame_chk(addr_reg, dhi_reg, dlo_reg));

  // A strobe in the timeout cycle takes priority, so the abort only fires
  // when no byte arrives that cycle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg   <= IDLE;
      addr_reg    <= 2'd0;
      dhi_reg     <= 8'd0;
      dlo_reg     <= 8'd0;
      tmo_cnt_reg <= '0;
      cfg_update  <= 1'b0;
      cfg_addr    <= 2'd0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      frame_err  <= 1'b0;

      if (state_reg == IDLE || byte_stb) begin
        tmo_cnt_reg <= '0;
      end else if (!tmo_hit) begin
        tmo_cnt_reg <= tmo_cnt_reg + CW'(1);
      end

      if (state_reg != IDLE && !byte_stb && tmo_hit) begin
        frame_err <= 1'b1;
        state_reg <= IDLE;
        busy      <= 1'b0;
      end else if (byte_stb) begin
        case (state_reg)
          IDLE: begin
            if (rx_data_in == HDR) begin
              state_reg <= ADDR;
              busy      <= 1'b1;
            end
          end
          ADDR: begin
            if (rx_data_in[7:2] != 6'd0) begin
              frame_err <= 1'b1;
              state_reg <= IDLE;
              busy      <= 1'b0;
            end else begin
              addr_reg  <= rx_data_in[1:0];
              state_reg <= DHI;
            end
          end
          DHI: begin
            dhi_reg   <= rx_data_in;
            state_reg <= DLO;
          end
          DLO: begin
            dlo_reg   <= rx_data_in;
            state_reg <= CHK;
          end
          CHK: begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            if (commit_stb) begin
              cfg_update <= 1'b1;
              cfg_addr   <= addr_reg;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  // One register per address; only the addressed one loads on commit.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cfg
    localparam logic [1:0] IDX = 2'(gi);
    logic [15:0] val_reg;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        val_reg <= rst_val(IDX);
      end else if (commit_stb && addr_reg == IDX) begin
        val_reg <= {dhi_reg, dlo_reg};
      end
    end
  end

  assign kp_out = g_cfg[0].val_reg;
  assign ki_out = g_cfg[1].val_reg;
  assign kd_out = g_cfg[2].val_reg;
  assign sp_out = g_cfg[3].val_reg;

endmodule

// File: tb/tb_uart_cfg_loader.sv
// Scoreboard bench for uart_cfg_loader: a byte-queue frame model predicts
// update/error events, a negedge monitor pops and compares them.
module tb_uart_cfg_loader;

  localparam int          T      = 50;
  localparam logic [15:0] KP_R   = 16'h1111;
  localparam logic [15:0] KI_R   = 16'h2222;
  localparam logic [15:0] KD_R   = 16'h3333;
  localparam logic [15:0] SP_R   = 16'h4444;
  localparam logic [63:0] RST_VEC = {SP_R, KD_R, KI_R, KP_R};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [15:0] kp, ki, kd, sp;
  logic        cfg_update, frame_err, busy;
  logic [1:0]  cfg_addr;

  uart_cfg_loader #(
    .HDR            (8'hA5),
    .TIMEOUT_CYCLES (T),
    .KP_RST         (KP_R),
    .KI_RST         (KI_R),
    .KD_RST         (KD_R),
    .SP_RST         (SP_R)
  ) dut (
    .clk_in     (clk),
    .rst_n_in   (rst_n),
    .rx_rdy_in  (rx_rdy),
    .rx_data_in (rx_data),
    .kp_out     (kp),
    .ki_out     (ki),
    .kd_out     (kd),
    .sp_out     (sp),
    .cfg_update (cfg_update),
    .cfg_addr   (cfg_addr),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    int          exp_cyc;
    logic [63:0] regs;
    logic [1:0]  addr;
  } ev_t;

  ev_t         q[$];
  logic [7:0]  frame_q[$];
  logic [63:0] m_regs = RST_VEC;
  logic [1:0]  m_addr = 2'd0;
  int          last_c = 0;
  int          checks = 0;
  int          errors = 0;

  // ---------------- reference model ----------------
  task automatic push_ev(input bit is_err, input int c);
    ev_t e;
    e.is_err  = is_err;
    e.exp_cyc = c + 1;
    e.regs    = m_regs;
    e.addr    = m_addr;
    q.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b, input int c);
    int a;
    if (frame_q.size() == 0) begin
      if (b == 8'hA5) frame_q.push_back(b);
      return;
    end
    frame_q.push_back(b);
    if (frame_q.size() == 2 && b > 8'd3) begin
      push_ev(1'b1, c);
      frame_q.delete();
    end else if (frame_q.size() == 5) begin
      if ((frame_q[1] ^ frame_q[2] ^ frame_q[3]) == frame_q[4]) begin
        a = int'(frame_q[1]);
        m_regs[a*16 +: 16] = {frame_q[2], frame_q[3]};
        m_addr = 2'(a);
        push_ev(1'b0, c);
      end else begin
        push_ev(1'b1, c);
      end
      frame_q.delete();
    end
  endtask

  task automatic model_timeout(input int c);
    if (frame_q.size() != 0) begin
      push_ev(1'b1, c + T);
      frame_q.delete();
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b, input int h, input int l);
    rx_data = b;
    rx_rdy  = 1'b1;
    last_c  = cyc;
    model_byte(b, cyc);
    repeat (h) @(posedge clk);
    #1;
    rx_rdy  = 1'b0;
    rx_data = 8'($urandom);
    repeat (l) @(posedge clk);
    #1;
    checks++;
    if (busy !== (frame_q.size() != 0)) begin
      errors++;
      $display("FAIL busy after byte %02h: got %b want %b", b, busy, frame_q.size() != 0);
    end
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input int n, input int h);
    logic [7:0] bs [5];
    bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3; bs[4] = b4;
    for (int i = 0; i < n; i++) send_byte(bs[i], h, 2);
  endtask

  task automatic idle_timeout(input int n);
    model_timeout(last_c);
    repeat (n) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy after timeout: got %b want 0", busy);
    end
  endtask

  task automatic do_reset(input int hold);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending events at reset: got %0d want 0", q.size());
      q.delete();
    end
    rst_n = 1'b0;
    frame_q.delete();
    m_regs = RST_VEC;
    m_addr = 2'd0;
    repeat (hold) @(posedge clk);
    #1;
    checks++;
    if ({sp, kd, ki, kp} !== RST_VEC || busy !== 1'b0 || cfg_update !== 1'b0 ||
        frame_err !== 1'b0 || cfg_addr !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: regs %016h busy %b upd %b err %b addr %0d want %016h 0 0 0 0",
               {sp, kd, ki, kp}, busy, cfg_update, frame_err, cfg_addr, RST_VEC);
    end
    rst_n = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  ev_t         mon_e;
  logic [63:0] cur_regs = RST_VEC;
  logic [1:0]  cur_addr = 2'd0;
  int          stab_prints = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      cur_regs = RST_VEC;
      cur_addr = 2'd0;
    end else if (cfg_update || frame_err) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event at cyc %0d: upd %b err %b, want none", cyc, cfg_update, frame_err);
      end else begin
        mon_e = q.pop_front();
        if (frame_err !== mon_e.is_err || cfg_update !== !mon_e.is_err || cyc != mon_e.exp_cyc) begin
          errors++;
          $display("FAIL event: got upd %b err %b cyc %0d, want %s at cyc %0d",
                   cfg_update, frame_err, cyc, mon_e.is_err ? "err" : "upd", mon_e.exp_cyc);
        end
        cur_regs = mon_e.regs;
        cur_addr = mon_e.addr;
        $display("event %s cyc %0d regs %016h addr %0d", mon_e.is_err ? "err" : "upd",
                 cyc, {sp, kd, ki, kp}, cfg_addr);
      end
    end
    checks++;
    if ({sp, kd, ki, kp} !== cur_regs || cfg_addr !== cur_addr) begin
      errors++;
      if (stab_prints < 20) begin
        stab_prints++;
        $display("FAIL regs at cyc %0d: got %016h addr %0d want %016h addr %0d",
                 cyc, {sp, kd, ki, kp}, cfg_addr, cur_regs, cur_addr);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] a, dh, dl, ck;
    int kind, k;

    do_reset(3);
    repeat (2) @(posedge clk);
    #1;

    send_frame(8'hA5, 8'h00, 8'h12, 8'h34, 8'h26, 5, 10);
    send_frame(8'hA5, 8'h01, 8'h00, 8'h10, 8'h00, 5, 4);
    send_frame(8'hA5, 8'h01, 8'h00, 8'h10, 8'h11, 5, 4);
    send_frame(8'hA5, 8'h07, 8'h12, 8'h34, 8'h56, 5, 3);
    send_frame(8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 2, 3);
    idle_timeout(60);
    send_frame(8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h64, 5, 3);

    // Level already high at reset release must not be taken as a byte.
    rx_rdy  = 1'b1;
    rx_data = 8'hA5;
    do_reset(3);
    repeat (20) @(posedge clk);
    #1;
    rx_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy after held level: got %b want 0", busy);
    end
    send_frame(8'hA5, 8'h03, 8'h00, 8'hFF, 8'hFC, 5, 3);

    // Reset in the middle of a frame, then the frame's tail bytes.
    send_frame(8'hA5, 8'h00, 8'h12, 8'h34, 8'h26, 5, 2);
    repeat (3) @(posedge clk);
    #1;
    send_frame(8'hA5, 8'h00, 8'h12, 8'h00, 8'h00, 3, 2);
    do_reset(2);
    repeat (2) @(posedge clk);
    #1;
    send_byte(8'h34, 2, 2);
    send_byte(8'h26, 2, 2);

    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 5);
      a  = 8'($urandom_range(0, 3));
      dh = 8'($urandom);
      dl = 8'($urandom);
      ck = a ^ dh ^ dl;
      case (kind)
        0, 1: send_frame(8'hA5, a, dh, dl, ck, 5, $urandom_range(1, 8));
        2: send_frame(8'hA5, a, dh, dl, ck ^ (8'h01 << $urandom_range(0, 7)), 5, $urandom_range(1, 8));
        3: send_frame(8'hA5, 8'($urandom_range(4, 255)), dh, dl, ck, 2, $urandom_range(1, 8));
        4: begin
          k = $urandom_range(1, 4);
          send_frame(8'hA5, a, dh, dl, ck, k, $urandom_range(1, 8));
          idle_timeout(60);
        end
        default: begin
          dh = 8'($urandom);
          if (dh == 8'hA5) dh = 8'h5A;
          send_byte(dh, $urandom_range(1, 8), $urandom_range(1, 6));
        end
      endcase
    end

    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d outstanding want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cfg_loader.md
Name: uart_cfg_loader

Overview:
- Command-frame parser that configures the PID core from the UART receiver.
- Detects rising edges of the UART `data_rdy` level, assembles fixed-length frames, verifies an XOR checksum, and writes one of four 16-bit configuration registers: Kp, Ki, Kd and setpoint.
- Sits between the UART RX and the PID datapath. It is the only writer of PID configuration.

Parameters:
- HDR, 8'hA5, frame start byte.
- TIMEOUT_CYCLES, 100000, maximum clk_in cycles allowed between bytes of one frame.
- KP_RST, 16'h0000, reset value of kp_out.
- KI_RST, 16'h0000, reset value of ki_out.
- KD_RST, 16'h0000, reset value of kd_out.
- SP_RST, 16'h0000, reset value of sp_out.

Ports:
- clk_in  input  1  system clock; single clock domain
- rst_n_in  input  1  asynchronous active-low reset
- rx_rdy_in  input  1  UART data_rdy level; held high while byte valid
- rx_data_in  input  8  UART received byte, stable while rx_rdy_in high
- kp_out  output  16  proportional gain
- ki_out  output  16  integral gain
- kd_out  output  16  derivative gain
- sp_out  output  16  setpoint
- cfg_update  output  1  one-cycle pulse when any register is written
- cfg_addr  output  2  index of the last written register
- frame_err  output  1  one-cycle pulse on a rejected frame
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: async assert, sync deassert.
  - kp/ki/kd/sp_out take KP_RST/KI_RST/KD_RST/SP_RST.
  - cfg_update, frame_err, cfg_addr and busy are 0.
  - FSM enters IDLE; the timeout counter is cleared.
  - The edge-delay flop resets to 1, so a high rx_rdy_in at reset release is not a byte.
- Byte strobe: `byte_stb = rx_rdy_in & ~rdy_d`.
  - Exactly one strobe per low-to-high transition, regardless of how long the level is held.
  - rx_data_in is sampled in the strobe cycle.
- Frame format: HDR, ADDR, D_HI, D_LO, CHK, where CHK = ADDR ^ D_HI ^ D_LO.
- FSM states: IDLE, ADDR, DHI, DLO, CHK.
  - IDLE: on strobe with byte == HDR go to ADDR; any other byte is ignored silently (no error).
  - ADDR: on strobe, if byte[7:2] != 0, pulse frame_err and go to IDLE. Otherwise latch addr[1:0] and go to DHI.
  - DHI: on strobe, latch the high data byte and go to DLO.
  - DLO: on strobe, latch the low data byte and go to CHK.
  - CHK: on strobe, compare the byte to the computed checksum.
    - Match: commit and go to IDLE.
    - Mismatch: pulse frame_err, go to IDLE, no register changes.
- Commit: in the cycle after the CHK strobe, the selected register holds the new value, cfg_update = 1 and cfg_addr = addr.
  - Latency is 1 clk_in from the CHK strobe to the visible value.
  - Address map: 0 = kp, 1 = ki, 2 = kd, 3 = sp.
- Timeout:
  - The counter clears on every strobe and in IDLE, and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1 outside IDLE: pulse frame_err, return to IDLE, discard partial data.
  - If a strobe arrives in the same cycle as the timeout, the strobe wins and the byte is processed.
- Register stability: outputs change only at commit, and at most one register changes per frame.
- Back-to-back frames: a HDR strobe may follow the CHK strobe immediately. The commit pulse and the new frame's start do not interfere.
- Reset mid-frame: all partial state is discarded and the outputs return to their reset values.
- Width: the counter width is $clog2(TIMEOUT_CYCLES). The counter saturates and never wraps.

Decomposition:
- Shared package uart_cfg_pkg holds:
  - FSM state enum: IDLE/ADDR/DHI/DLO/CHK.
  - Address constants ADDR_KP=0, ADDR_KI=1, ADDR_KD=2, ADDR_SP=3.
  - Default HDR value.
- One sub-module, rdy_edge_sync: a resettable rising-edge detector with delay-flop reset value 1. It produces byte_stb.
- The FSM, data latches and config register file remain in the top.

Test Plan:
- Good frame A5 00 12 34 26, each byte held 10 cycles -> kp_out=16'h1234 one cycle after the 5th strobe, cfg_update pulses 1 cycle, cfg_addr=0, other registers unchanged.
- Bad checksum A5 01 00 10 00 (expected 11) -> frame_err pulses once, ki_out unchanged, busy drops; a following A5 01 00 10 11 -> ki_out=16'h0010.
- Invalid address A5 07 ... -> frame_err on the ADDR strobe, FSM in IDLE, remaining bytes ignored (no HDR present).
- Timeout with TIMEOUT_CYCLES=50: send A5 02 then idle 60 cycles -> frame_err pulses once; then A5 02 AB CD 64 -> kd_out=16'hABCD.
- rx_rdy_in high at reset release for 20 cycles with data=A5, then a normal A5 03 00 FF FC -> the first level is ignored; sp_out=16'h00FF.
- Reset asserted mid-frame after A5 00 12 -> outputs return to reset values, busy=0; the bytes 34 26 that follow do not update kp_out.
